tidc_l2_responder: RTL and testbench
====================================

TIDC_L2_RESPONDER -- requirements
Module: tidc_l2_responder

Interface
REQ-001 SHALL have parameter DEPTH_LINES, default 1024: number of 256-bit lines in backing store.
REQ-002 SHALL have parameter LATENCY, default 4: cycles from the start of service to the response pulse; legal range 2..15.
REQ-003 SHALL have parameter QDEPTH, default 4: command FIFO entries, power of two.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port l2_cmd_valid, input, 1 bit: single-cycle command strobe with no backpressure.
REQ-007 SHALL have port l2_cmd_type, input, 3 bits: L2_CMD_READ, L2_CMD_WRITE or L2_CMD_WRITE_BACK, encoded per tidc_params.v.
REQ-008 SHALL have port l2_cmd_addr, input, 32 bits: byte address; line index = addr[31:5].
REQ-009 SHALL have port l2_cmd_data, input, 256 bits: write data.
REQ-010 SHALL have port l2_cmd_size, input, 4 bits: ignored.
REQ-011 SHALL have port l2_cmd_dirty, input, 1 bit: write-back carries modified data.
REQ-012 SHALL have port l2_response_valid, output, 1 bit: one-cycle response pulse.
REQ-013 SHALL have port l2_response_data, output, 256 bits: response data.
REQ-014 SHALL have port l2_response_error, output, 1 bit: qualified by l2_response_valid.
REQ-015 SHALL have port busy, output, 1 bit: FIFO non-empty or FSM not IDLE.
REQ-016 SHALL have port overflow, output, 1 bit: sticky, a command was dropped.

Function
REQ-017 SHALL capture {type, addr, data, dirty} into the FIFO on every clk edge where l2_cmd_valid=1 and the FIFO is not full.
REQ-018 SHALL drop the command and set overflow=1 when l2_cmd_valid=1 and the FIFO is full; overflow stays 1 until reset.
REQ-019 SHALL treat a simultaneous push and pop on a full FIFO as full, so the incoming command is dropped.
REQ-020 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-021 SHALL, in IDLE, pop the FIFO head when it is non-empty, load the wait counter with LATENCY-2, and go to WAIT.
REQ-022 SHALL, in WAIT, decrement the counter and go to RESP when the counter is 0.
REQ-023 SHALL, in RESP, assert l2_response_valid for exactly one cycle and then return to IDLE.
REQ-024 SHALL, for a command strobed at edge T into an empty FIFO with the FSM in IDLE, make the response visible after edge T+LATENCY.
REQ-025 SHALL service queued commands in strict FIFO order, with the next pop occurring in the IDLE cycle after RESP.
REQ-026 SHALL flag an out-of-range command (addr[31:5] >= DEPTH_LINES) with error=1 and data=0, leaving the memory untouched.
REQ-027 SHALL, on READ, return data = mem[index] and error=0.
REQ-028 SHALL, on WRITE, perform mem[index] <= cmd data, return data = cmd data and error=0.
REQ-029 SHALL, on WRITE_BACK with dirty=1, behave as WRITE.
REQ-030 SHALL, on WRITE_BACK with dirty=0, leave the memory unchanged and return data = mem[index] with error=0.
REQ-031 SHALL answer any other cmd_type with error=1, data=0 and no memory update.
REQ-032 SHALL perform the memory update on the RESP-entry edge, so a later queued READ of the same line returns the new data.
REQ-033 SHALL hold l2_response_data and l2_response_error at their last values when l2_response_valid=0.

Reset
REQ-034 SHALL, on rst_n=0 at any time, immediately clear l2_response_valid, l2_response_error, l2_response_data (to 0), busy and overflow, empty the FIFO, and force the FSM to IDLE.
REQ-035 SHALL discard in-flight and queued commands at reset with no late response.
REQ-036 SHALL neither reset nor clear memory contents; contents are undefined after power-up.
REQ-037 SHALL sample no commands during reset and SHALL accept commands from the first edge after rst_n deasserts.

Verification
REQ-038 SHALL cover: WRITE addr 0x1000 data 0xAB..AB, then READ 0x1000 -> read response data 0xAB..AB, error=0, valid exactly 4 cycles after the READ strobe when idle.
REQ-039 SHALL cover: 4 back-to-back strobes (W 0x2000, R 0x2000, W 0x2020, R 0x2020) -> 4 responses in order, spaced 5 cycles apart, reads return the written data, overflow=0.
REQ-040 SHALL cover: 6 strobes on consecutive cycles -> exactly 5 responses (one in service plus 4 queued), the 6th dropped, overflow=1 until reset.
REQ-041 SHALL cover: READ addr 0x00008000 with DEPTH_LINES=1024 -> error=1, data=0; an undefined type 3'b111 -> error=1.
REQ-042 SHALL cover: WRITE_BACK dirty=0 to a line holding 0x55..55 with cmd data 0xFF..FF -> response 0x55..55, and a later READ returns 0x55..55.
REQ-043 SHALL cover: rst_n asserted 2 cycles after a READ strobe -> no response pulse, busy=0, and memory retains previously written lines.

Source files
------------

// File: rtl/tidc_l2_responder.sv
// L2 responder model: queues L2 commands in a small FIFO and answers each one
// LATENCY cycles after service starts, backed by a line-wide memory.
module tidc_l2_responder #(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4,
    parameter int QDEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         l2_cmd_valid,
    input  logic [2:0]   l2_cmd_type,
    input  logic [31:0]  l2_cmd_addr,
    input  logic [255:0] l2_cmd_data,
    input  logic [3:0]   l2_cmd_size,
    input  logic         l2_cmd_dirty,
    output logic         l2_response_valid,
    output logic [255:0] l2_response_data,
    output logic         l2_response_error,
    output logic         busy,
    output logic         overflow
);
    localparam logic [2:0] L2_CMD_READ       = 3'd0;
    localparam logic [2:0] L2_CMD_WRITE      = 3'd1;
    localparam logic [2:0] L2_CMD_WRITE_BACK = 3'd2;
    localparam int IDXW = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [2:0]   q_type  [QDEPTH];
    logic [26:0]  q_line  [QDEPTH];
    logic [255:0] q_data  [QDEPTH];
    logic         q_dirty [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic full, empty, push, pop;

    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic resp_enter;

    logic [2:0]   cur_type;
    logic [26:0]  cur_line;
    logic [255:0] cur_data;
    logic         cur_dirty;

    logic [255:0] mem [DEPTH_LINES];
    logic [255:0] rd_data, resp_data_d;
    logic         resp_err_d, mem_we, in_range;

    logic unused_in;
    assign unused_in = ^{l2_cmd_size, l2_cmd_addr[4:0]};

    assign full  = (count == (PW+1)'(QDEPTH));
    assign empty = (count == '0);
    // A pop in the same cycle does not make room: a full FIFO always drops.
    assign push  = l2_cmd_valid && !full;
    assign busy  = !empty || (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (l2_cmd_valid && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_type[wr_ptr]  <= l2_cmd_type;
            q_line[wr_ptr]  <= l2_cmd_addr[31:5];
            q_data[wr_ptr]  <= l2_cmd_data;
            q_dirty[wr_ptr] <= l2_cmd_dirty;
        end
        if (pop) begin
            cur_type  <= q_type[rd_ptr];
            cur_line  <= q_line[rd_ptr];
            cur_data  <= q_data[rd_ptr];
            cur_dirty <= q_dirty[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        pop        = 1'b0;
        resp_enter = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = 4'(LATENCY - 2);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    resp_enter = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_range = ({5'd0, cur_line} < 32'(DEPTH_LINES));
    assign rd_data  = mem[cur_line[IDXW-1:0]];

    always_comb begin
        resp_data_d = '0;
        resp_err_d  = 1'b0;
        mem_we      = 1'b0;
        if (!in_range) begin
            resp_err_d = 1'b1;
        end else begin
            case (cur_type)
                L2_CMD_READ:  resp_data_d = rd_data;
                L2_CMD_WRITE: begin
                    mem_we      = 1'b1;
                    resp_data_d = cur_data;
                end
                L2_CMD_WRITE_BACK: begin
                    if (cur_dirty) begin
                        mem_we      = 1'b1;
                        resp_data_d = cur_data;
                    end else begin
                        resp_data_d = rd_data;
                    end
                end
                default: resp_err_d = 1'b1;
            endcase
        end
    end

    // Memory is intentionally never reset; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (resp_enter && mem_we) mem[cur_line[IDXW-1:0]] <= cur_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_response_valid <= 1'b0;
            l2_response_data  <= '0;
            l2_response_error <= 1'b0;
        end else begin
            l2_response_valid <= resp_enter;
            if (resp_enter) begin
                l2_response_data  <= resp_data_d;
                l2_response_error <= resp_err_d;
            end
        end
    end
endmodule

// File: tb/tb_tidc_l2_responder.sv
// Directed bench for tidc_l2_responder: latency, ordering, overflow, error
// cases, write-back semantics and mid-flight reset.
module tb_tidc_l2_responder;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         l2_cmd_valid = 1'b0;
    logic [2:0]   l2_cmd_type = '0;
    logic [31:0]  l2_cmd_addr = '0;
    logic [255:0] l2_cmd_data = '0;
    logic [3:0]   l2_cmd_size = '0;
    logic         l2_cmd_dirty = 1'b0;
    logic         l2_response_valid;
    logic [255:0] l2_response_data;
    logic         l2_response_error;
    logic         busy;
    logic         overflow;

    tidc_l2_responder #(.DEPTH_LINES(1024), .LATENCY(4), .QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .l2_cmd_valid(l2_cmd_valid), .l2_cmd_type(l2_cmd_type),
        .l2_cmd_addr(l2_cmd_addr), .l2_cmd_data(l2_cmd_data),
        .l2_cmd_size(l2_cmd_size), .l2_cmd_dirty(l2_cmd_dirty),
        .l2_response_valid(l2_response_valid), .l2_response_data(l2_response_data),
        .l2_response_error(l2_response_error), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] RD = 3'd0, WR = 3'd1, WB = 3'd2, BAD = 3'b111;

    typedef struct {
        int           cyc;
        logic [255:0] data;
        logic         err;
    } resp_t;

    resp_t rq[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (l2_response_valid === 1'b1) rq.push_back('{cyc, l2_response_data, l2_response_error});
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [2:0] t, input logic [31:0] a,
                           input logic [255:0] d, input logic dirty);
        l2_cmd_valid = 1'b1;
        l2_cmd_type  = t;
        l2_cmd_addr  = a;
        l2_cmd_data  = d;
        l2_cmd_dirty = dirty;
        l2_cmd_size  = 4'hF;
    endtask

    task automatic clr_cmd();
        l2_cmd_valid = 1'b0;
        l2_cmd_dirty = 1'b0;
    endtask

    // One strobe; returns the index of the capturing edge.
    task automatic strobe(input logic [2:0] t, input logic [31:0] a,
                          input logic [255:0] d, input logic dirty, output int tc);
        @(negedge clk);
        set_cmd(t, a, d, dirty);
        @(negedge clk);
        tc = cyc;
        clr_cmd();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic [255:0] d_ab, d_55, d_ff, d_cc, d1, d2;

    initial begin
        d_ab = {32{8'hAB}};
        d_55 = {32{8'h55}};
        d_ff = {32{8'hFF}};
        d_cc = {32{8'hCC}};
        d1   = {8{32'h1234_5678}};
        d2   = {8{32'hDEAD_BEEF}};

        // Reset state
        wait_cycles(3);
        chk("rst_valid", 256'(l2_response_valid), 256'(0));
        chk("rst_data", l2_response_data, '0);
        chk("rst_err", 256'(l2_response_error), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        rst_n = 1'b1;

        // WRITE then READ 0x1000, exact latency
        strobe(WR, 32'h1000, d_ab, 1'b0, t0);
        wait_cycles(10);
        chk("wr_nresp", 256'(rq.size()), 256'(1));
        if (rq.size() > 0) chk("wr_data", rq[0].data, d_ab);
        rq.delete();
        strobe(RD, 32'h1000, '0, 1'b0, t0);
        chk("rd_busy", 256'(busy), 256'(1));
        wait_cycles(10);
        chk("rd_nresp", 256'(rq.size()), 256'(1));
        if (rq.size() > 0) begin
            chk("rd_lat", 256'(rq[0].cyc - t0), 256'(4));
            chk("rd_data", rq[0].data, d_ab);
            chk("rd_err", 256'(rq[0].err), 256'(0));
        end
        chk("hold_data", l2_response_data, d_ab);
        chk("idle_busy", 256'(busy), 256'(0));
        rq.delete();

        // Four back-to-back strobes
        @(negedge clk); set_cmd(WR, 32'h2000, d1, 1'b0);
        @(negedge clk); t0 = cyc; set_cmd(RD, 32'h2000, '0, 1'b0);
        @(negedge clk); set_cmd(WR, 32'h2020, d2, 1'b0);
        @(negedge clk); set_cmd(RD, 32'h2020, '0, 1'b0);
        @(negedge clk); clr_cmd();
        wait_cycles(30);
        chk("b2b_nresp", 256'(rq.size()), 256'(4));
        if (rq.size() == 4) begin
            chk("b2b_t0", 256'(rq[0].cyc - t0), 256'(4));
            chk("b2b_t1", 256'(rq[1].cyc - t0), 256'(9));
            chk("b2b_t2", 256'(rq[2].cyc - t0), 256'(14));
            chk("b2b_t3", 256'(rq[3].cyc - t0), 256'(19));
            chk("b2b_d0", rq[0].data, d1);
            chk("b2b_d1", rq[1].data, d1);
            chk("b2b_d2", rq[2].data, d2);
            chk("b2b_d3", rq[3].data, d2);
        end
        chk("b2b_ovf", 256'(overflow), 256'(0));
        rq.delete();

        // Six consecutive strobes: one in service, four queued, one dropped
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            set_cmd(WR, 32'h3000 + 32'(i * 32), 256'(i + 1), 1'b0);
            @(negedge clk);
        end
        clr_cmd();
        wait_cycles(40);
        chk("ovf_nresp", 256'(rq.size()), 256'(5));
        if (rq.size() == 5) chk("ovf_last", rq[4].data, 256'(5));
        chk("ovf_flag", 256'(overflow), 256'(1));
        wait_cycles(5);
        chk("ovf_sticky", 256'(overflow), 256'(1));
        rq.delete();
        rst_n = 1'b0;
        #1;
        chk("ovf_rst", 256'(overflow), 256'(0));
        chk("rst_data2", l2_response_data, '0);
        wait_cycles(2);
        rst_n = 1'b1;

        // Out-of-range address and undefined type
        strobe(RD, 32'h0000_8000, '0, 1'b0, t0);
        wait_cycles(8);
        chk("oor_nresp", 256'(rq.size()), 256'(1));
        if (rq.size() > 0) begin
            chk("oor_err", 256'(rq[0].err), 256'(1));
            chk("oor_data", rq[0].data, '0);
        end
        rq.delete();
        strobe(BAD, 32'h1000, d_ff, 1'b0, t0);
        wait_cycles(8);
        chk("bad_nresp", 256'(rq.size()), 256'(1));
        if (rq.size() > 0) begin
            chk("bad_err", 256'(rq[0].err), 256'(1));
            chk("bad_data", rq[0].data, '0);
        end
        rq.delete();

        // Write-back clean vs dirty
        strobe(WR, 32'h4000, d_55, 1'b0, t0);
        strobe(WB, 32'h4000, d_ff, 1'b0, t0);
        strobe(RD, 32'h4000, '0, 1'b0, t0);
        strobe(WB, 32'h4020, d_cc, 1'b1, t0);
        strobe(RD, 32'h4020, '0, 1'b0, t0);
        strobe(RD, 32'h1000, '0, 1'b0, t0);
        wait_cycles(30);
        chk("wb_nresp", 256'(rq.size()), 256'(6));
        if (rq.size() == 6) begin
            chk("wb_clean", rq[1].data, d_55);
            chk("wb_clean_rd", rq[2].data, d_55);
            chk("wb_dirty", rq[3].data, d_cc);
            chk("wb_dirty_rd", rq[4].data, d_cc);
            chk("bad_no_write", rq[5].data, d_ab);
        end
        rq.delete();

        // Reset two cycles after a READ strobe
        strobe(RD, 32'h1000, '0, 1'b0, t0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 256'(busy), 256'(0));
        chk("mid_valid", 256'(l2_response_valid), 256'(0));
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(10);
        chk("mid_noresp", 256'(rq.size()), 256'(0));
        strobe(RD, 32'h2000, '0, 1'b0, t0);
        wait_cycles(8);
        chk("ret_nresp", 256'(rq.size()), 256'(1));
        if (rq.size() > 0) begin
            chk("ret_lat", 256'(rq[0].cyc - t0), 256'(4));
            chk("ret_data", rq[0].data, d1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
